// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
//
// Contents: mult_state_t, the three-state control encoding.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add N x N -> 2N multiplier, unsigned or two's complement per operation.
// Latency: result valid N cycles after the accept edge, independent of operand values.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE with out_ready.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start, in_ready   operand handshake (A, B, signed_mode sampled on accept)
//   A, B              multiplicand / multiplier, N bits
//   Q, out_valid      2N-bit product and its valid flag; Q held until next completion
//   out_ready         consumer accepts Q
//   busy              high while iterating (CALC)
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    output logic           in_ready,
    input  logic           signed_mode,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] Q,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    localparam int CNT_W = $clog2(N);

    mult_state_t      state;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     mag_a;
    logic             neg;

    // Product register: the upper half is the running accumulator, the lower
    // half starts as the multiplier magnitude. Each step shifts one product bit
    // in from the top while the consumed multiplier bit falls off the bottom,
    // so P[0] is always the multiplier bit to apply this cycle.
    logic [2*N-1:0]   prod;

    logic             accept;
    logic [N-1:0]     abs_a;
    logic [N-1:0]     abs_b;
    logic [N:0]       sum;
    logic [2*N-1:0]   prod_next;
    logic [2*N-1:0]   result;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = start && in_ready;

    // Magnitudes fit in N unsigned bits even for the most negative operand.
    assign abs_a = (signed_mode && A[N-1]) ? (~A + 1'b1) : A;
    assign abs_b = (signed_mode && B[N-1]) ? (~B + 1'b1) : B;

    always_comb begin
        sum       = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mag_a} : '0);
        prod_next = {sum, prod[N-1:1]};
        result    = neg ? (~prod_next + 1'b1) : prod_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            prod      <= '0;
            mag_a     <= '0;
            neg       <= 1'b0;
            Q         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (state == DONE && out_ready)
                        out_valid <= 1'b0;
                    if (accept) begin
                        mag_a <= abs_a;
                        neg   <= signed_mode && (A[N-1] ^ B[N-1]);
                        prod  <= {{N{1'b0}}, abs_b};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    prod  <= prod_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(N - 1)) begin
                        Q         <= result;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=4) with an expected-result queue.
// Latency: checks the fixed N-cycle accept-to-valid delay on every operation.
// Backpressure: exercises out_ready stalls, back-to-back accepts and mid-operation reset.
module tb_seq_multiplier;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           in_ready;
    logic           signed_mode;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] Q;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    int total = 0;
    int bad   = 0;
    logic [2*N-1:0] sb[$];

    seq_multiplier #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b, input logic sm);
        int x;
        int y;
        int p;
        x = sm ? int'($signed(a)) : int'(a);
        y = sm ? int'($signed(b)) : int'(b);
        p = x * y;
        return p[7:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one operation and pass the accept edge; leaves the bench in CALC cycle 1.
    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic sm);
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        sb.push_back(ref_mul(a, b, sm));
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency and pop the expected product.
    task automatic collect(input string tag, output logic [7:0] q);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!out_valid && cyc < 20);
        check({tag, "_lat"}, 32'(cyc), 32'(N));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            check({tag, "_q"}, 32'(Q), 32'(sb.pop_front()));
        end
        q = Q;
    endtask

    initial begin
        logic [7:0] q;

        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;
        out_ready   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_q",     32'(Q),         32'(0));
        check("rst_rdy",   32'(in_ready),  32'(1));

        // Unsigned max x max.
        launch(4'hF, 4'hF, 1'b0);
        check("calc_busy", 32'(busy), 32'(1));
        check("calc_rdy",  32'(in_ready), 32'(0));
        collect("umax", q);
        check("umax_lit", 32'(q), 32'(8'hE1));
        check("done_rdy", 32'(in_ready), 32'(1));
        tick();
        check("xfer_valid", 32'(out_valid), 32'(0));
        check("hold_q", 32'(Q), 32'(8'hE1));

        // Signed cases, then the same bit pattern unsigned.
        launch(4'h8, 4'h8, 1'b1); collect("s_m8m8", q); check("s_m8m8_lit", 32'(q), 32'(8'h40)); tick();
        launch(4'h8, 4'h7, 1'b1); collect("s_m8p7", q); check("s_m8p7_lit", 32'(q), 32'(8'hC8)); tick();
        launch(4'hF, 4'h1, 1'b1); collect("s_m1p1", q); check("s_m1p1_lit", 32'(q), 32'(8'hFF)); tick();
        launch(4'hF, 4'h1, 1'b0); collect("u_f1",   q); check("u_f1_lit",   32'(q), 32'(8'h0F)); tick();
        launch(4'h0, 4'h9, 1'b1); collect("s_zero", q); check("s_zero_lit", 32'(q), 32'(8'h00)); tick();

        // Back-to-back: new operands accepted straight out of DONE.
        launch(4'd3, 4'd5, 1'b0);
        collect("b2b1", q);
        check("b2b1_lit", 32'(q), 32'(8'h0F));
        check("b2b_rdy", 32'(in_ready), 32'(1));
        A           = 4'd6;
        B           = 4'd7;
        signed_mode = 1'b0;
        start       = 1'b1;
        sb.push_back(ref_mul(4'd6, 4'd7, 1'b0));
        tick();
        start = 1'b0;
        check("b2b_busy",  32'(busy),      32'(1));
        check("b2b_valid", 32'(out_valid), 32'(0));
        collect("b2b2", q);
        check("b2b2_lit", 32'(q), 32'(8'h2A));
        tick();

        // Stall: result held, start ignored, a single transfer on release.
        launch(4'd5, 4'd3, 1'b0);
        out_ready = 1'b0;
        collect("stall", q);
        A     = 4'd9;
        B     = 4'd9;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_rdy",   32'(in_ready),  32'(0));
            tick();
            check("stall_valid", 32'(out_valid), 32'(1));
            check("stall_q",     32'(Q),         32'(8'h0F));
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rel_valid", 32'(out_valid), 32'(0));
        check("rel_busy",  32'(busy),      32'(0));
        tick();
        check("rel_valid2", 32'(out_valid), 32'(0));
        check("rel_busy2",  32'(busy),      32'(0));

        // Reset in the second CALC cycle discards the operation.
        launch(4'd9, 4'd9, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_back());
        check("mrst_valid", 32'(out_valid), 32'(0));
        check("mrst_busy",  32'(busy),      32'(0));
        check("mrst_q",     32'(Q),         32'(0));
        check("mrst_rdy",   32'(in_ready),  32'(1));
        launch(4'd2, 4'd3, 1'b0);
        collect("after_rst", q);
        check("after_rst_lit", 32'(q), 32'(8'h06));
        tick();

        // Exhaustive sweep in both modes.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    launch(4'(a), 4'(b), 1'(s));
                    collect("sweep", q);
                    tick();
                    check("sweep_xfer", 32'(out_valid), 32'(0));
                end
            end
        end

        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier; the iterative, area-lean successor to the combinational array multiplier.
- Computes an N x N -> 2N product over N clock cycles, one partial product per cycle.
- Supports an unsigned or two's-complement signed mode, selected per operation.
- Operand and result transfer use a ready/valid-style handshake, so the block can sit between register-file or datapath stages.

Parameters:
- N, 4, operand width in bits; must be >= 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply; operands are valid while high.
- in_ready  output  1  block can accept start this cycle.
- signed_mode  input  1  1 = A and B are two's complement, 0 = unsigned; sampled with start.
- A  input  N  multiplicand.
- B  input  N  multiplier.
- Q  output  2N  product; stable while out_valid is high.
- out_valid  output  1  Q holds a completed result.
- out_ready  input  1  consumer accepts Q this cycle.
- busy  output  1  high in CALC state.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (sampled high at an edge, any state, including mid-CALC or DONE): state=IDLE, Q=0, out_valid=0, busy=0, internal count=0, accumulator=0. Any in-flight operation is discarded.
- in_ready = (state==IDLE) or (state==DONE and out_ready). It is combinational from state and out_ready.
- Accept: an edge with start and in_ready both high. On accept:
  - Capture magA and magB. In signed mode these are the absolute values (|-2^(N-1)| = 2^(N-1) fits in N unsigned bits); otherwise they are the raw operands.
  - Capture neg = signed_mode and (A[N-1] xor B[N-1]).
  - Clear the accumulator and set count=0; state->CALC.
- start when in_ready=0 is ignored; no queuing.
- CALC, each edge:
  - If multiplier LSB is 1, add magA to the upper N bits of the accumulator with an N+1-bit sum.
  - Shift {carry, accumulator} right by 1; shift the multiplier right by 1; count++.
  - On the edge where count==N-1, also load Q = neg ? -(accumulator result) : accumulator result (2N-bit two's complement) and go to DONE.
- Latency: accept at edge t; CALC occupies edges t+1..t+N; out_valid is first high after edge t+N. The first result is visible N cycles after the accept edge, fixed and data-independent.
- DONE:
  - out_valid=1 and Q is held.
  - If out_ready=1 and start=0: go to IDLE and clear out_valid.
  - If out_ready=1 and start=1: back-to-back; accept the new operands and go to CALC with out_valid cleared.
  - If out_ready=0: hold indefinitely.
- Q is held after out_valid falls until the next completion overwrites it.
- Boundaries:
  - A zero operand gives Q=0, including in signed mode where -0 = 0.
  - Signed -2^(N-1) x -2^(N-1) = 2^(2N-2), positive, no overflow.
  - Unsigned max x max = (2^N-1)^2.
- Widths: the accumulator is 2N bits plus 1 carry bit; count width is $clog2(N).

Decomposition:
- Package mult_pkg holds typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t.
- A localparam for count width lives in the module (it depends on N).
- No sub-module: the single N+1-bit add-and-shift datapath and 3-state FSM fit comfortably in one module.

Test Plan:
- N=4, unsigned, A=15, B=15, out_ready=1 -> out_valid exactly 4 cycles after accept, Q=8'hE1; in_ready high in the DONE cycle.
- N=4, signed: A=-8, B=-8 -> Q=8'h40. A=-8, B=7 -> Q=8'hC8. A=-1, B=1 -> Q=8'hFF. Repeat A=4'hF, B=4'h1 unsigned -> Q=8'h0F, showing the mode is sampled per operation.
- Back-to-back: out_ready=1, start held high with new operands in the DONE cycle (3x5, then 6x7 unsigned) -> Q=8'h0F, then Q=8'h2A four cycles later; no IDLE cycle in between.
- Stall: out_ready=0 for 10 cycles after done -> out_valid and Q=product held constant; in_ready=0 and start ignored; releasing out_ready yields exactly one transfer.
- Reset mid-operation: assert reset at the 2nd CALC cycle -> next cycle state IDLE, out_valid=0, busy=0, Q=0; a following 2x3 multiply returns Q=8'h06 with normal latency.
- Exhaustive N=4 sweep, both modes, against a $signed/unsigned reference model -> all 512 products match.
